// File: rtl/riscv_core_pkg.sv
// Shared encodings for the RV64I multi-cycle core:
// FSM states, opcodes and datapath select codes.
package riscv_core_pkg;

  localparam logic [3:0] S_BOOT   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXECR  = 4'd7;
  localparam logic [3:0] S_EXECI  = 4'd8;
  localparam logic [3:0] S_ALUWB  = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JALR   = 4'd11;
  localparam logic [3:0] S_JAL    = 4'd12;
  localparam logic [3:0] S_UIMM   = 4'd13;
  localparam logic [3:0] S_TRAP   = 4'd14;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_RW    = 7'b0111011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_IW    = 7'b0011011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_CMP = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // DECODE dispatch; unknown opcodes go to TRAP
  function automatic logic [3:0] dispatch(
    input logic [6:0] op
  );
    logic [3:0] s;
    case (op)
      OP_LOAD, OP_STORE: s = S_MEMADR;
      OP_R, OP_RW:       s = S_EXECR;
      OP_I, OP_IW:       s = S_EXECI;
      OP_BR:             s = S_BRANCH;
      OP_JAL:            s = S_JAL;
      OP_JALR:           s = S_JALR;
      OP_LUI, OP_AUIPC:  s = S_UIMM;
      default:           s = S_TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/riscv_core_mcctrl_timeout.sv
// Memory wait counter: counts unanswered request
// cycles and flags expiry at the limit.
module riscv_core_mcctrl_timeout #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_inc,
  input  logic i_ready,
  output logic o_expired
);

  localparam logic [TO_W-1:0] LIMIT =
    TO_W'(MEM_TIMEOUT);

  logic [TO_W-1:0] r_cnt;
  logic            w_wait;

  assign w_wait = i_inc && !i_ready;

  // a ready arriving at the limit still wins
  assign o_expired = w_wait && (r_cnt == LIMIT);

  // clear on entry, saturating count while waiting
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (w_wait && r_cnt != LIMIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/riscv_core_mcctrl.sv
// Multi-cycle main control FSM of the RV64I core:
// sequences fetch/decode/execute/memory/writeback.
module riscv_core_mcctrl
  import riscv_core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic       i_mcctrl_clk,
  input  logic       i_mcctrl_rst_n,
  input  logic [6:0] i_mcctrl_opcode,
  input  logic       i_mcctrl_mem_ready,
  input  logic       i_mcctrl_take,
  input  logic       i_mcctrl_trap_clr,
  output logic       o_mcctrl_pcwrite,
  output logic       o_mcctrl_irwrite,
  output logic       o_mcctrl_regwrite,
  output logic       o_mcctrl_memreq,
  output logic       o_mcctrl_memwe,
  output logic       o_mcctrl_adrsrc,
  output logic [2:0] o_mcctrl_immsrc,
  output logic [1:0] o_mcctrl_alusrca,
  output logic [1:0] o_mcctrl_alusrcb,
  output logic [1:0] o_mcctrl_aluop,
  output logic [1:0] o_mcctrl_resultsrc,
  output logic       o_mcctrl_illegal,
  output logic       o_mcctrl_buserr,
  output logic [3:0] o_mcctrl_state
);

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       r_illegal;
  logic       r_buserr;
  logic       w_expired;
  logic       w_clear;
  logic       w_rdy;

  assign w_rdy = i_mcctrl_mem_ready;

  assign w_clear = (w_next != r_state) &&
                   (w_next == S_FETCH ||
                    w_next == S_MEMRD ||
                    w_next == S_MEMWR);

  riscv_core_mcctrl_timeout #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_timeout (
    .i_clk     (i_mcctrl_clk),
    .i_rst_n   (i_mcctrl_rst_n),
    .i_clear   (w_clear),
    .i_inc     (o_mcctrl_memreq),
    .i_ready   (w_rdy),
    .o_expired (w_expired)
  );

  // state register
  always_ff @(posedge i_mcctrl_clk or negedge i_mcctrl_rst_n) begin
    if (!i_mcctrl_rst_n) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_next;
    end
  end

  // sticky trap cause flags, cleared on leaving TRAP
  always_ff @(posedge i_mcctrl_clk or negedge i_mcctrl_rst_n) begin
    if (!i_mcctrl_rst_n) begin
      r_illegal <= 1'b0;
      r_buserr  <= 1'b0;
    end else if (r_state == S_TRAP && i_mcctrl_trap_clr) begin
      r_illegal <= 1'b0;
      r_buserr  <= 1'b0;
    end else begin
      if (r_state == S_DECODE && w_next == S_TRAP)
        r_illegal <= 1'b1;
      if (w_expired)
        r_buserr <= 1'b1;
    end
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_BOOT:   w_next = S_FETCH;
      S_FETCH: begin
        if (w_rdy)          w_next = S_DECODE;
        else if (w_expired) w_next = S_TRAP;
      end
      S_DECODE: w_next = dispatch(i_mcctrl_opcode);
      S_MEMADR: w_next = i_mcctrl_opcode[5] ?
                         S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (w_rdy)          w_next = S_MEMWB;
        else if (w_expired) w_next = S_TRAP;
      end
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR: begin
        if (w_rdy)          w_next = S_FETCH;
        else if (w_expired) w_next = S_TRAP;
      end
      S_EXECR:  w_next = S_ALUWB;
      S_EXECI:  w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JALR:   w_next = S_JAL;
      S_JAL:    w_next = S_ALUWB;
      S_UIMM:   w_next = S_ALUWB;
      S_TRAP: begin
        if (i_mcctrl_trap_clr) w_next = S_FETCH;
      end
      default:  w_next = S_BOOT;
    endcase
  end

  // Moore output decode, plus ready/take strobes
  always_comb begin
    o_mcctrl_pcwrite   = 1'b0;
    o_mcctrl_irwrite   = 1'b0;
    o_mcctrl_regwrite  = 1'b0;
    o_mcctrl_memreq    = 1'b0;
    o_mcctrl_memwe     = 1'b0;
    o_mcctrl_adrsrc    = 1'b0;
    o_mcctrl_immsrc    = IMM_I;
    o_mcctrl_alusrca   = SRCA_PC;
    o_mcctrl_alusrcb   = SRCB_RS2;
    o_mcctrl_aluop     = ALUOP_ADD;
    o_mcctrl_resultsrc = RES_ALUOUT;
    case (r_state)
      S_FETCH: begin
        o_mcctrl_memreq    = 1'b1;
        o_mcctrl_alusrcb   = SRCB_FOUR;
        o_mcctrl_resultsrc = RES_ALU;
        o_mcctrl_irwrite   = w_rdy;
        o_mcctrl_pcwrite   = w_rdy;
      end
      S_DECODE: begin
        o_mcctrl_alusrca = SRCA_OLDPC;
        o_mcctrl_alusrcb = SRCB_IMM;
        o_mcctrl_immsrc  =
          (i_mcctrl_opcode == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        o_mcctrl_alusrca = SRCA_RS1;
        o_mcctrl_alusrcb = SRCB_IMM;
        o_mcctrl_immsrc  =
          i_mcctrl_opcode[5] ? IMM_S : IMM_I;
      end
      S_MEMRD: begin
        o_mcctrl_memreq = 1'b1;
        o_mcctrl_adrsrc = 1'b1;
      end
      S_MEMWB: begin
        o_mcctrl_resultsrc = RES_MEM;
        o_mcctrl_regwrite  = 1'b1;
      end
      S_MEMWR: begin
        o_mcctrl_memreq = 1'b1;
        o_mcctrl_memwe  = 1'b1;
        o_mcctrl_adrsrc = 1'b1;
      end
      S_EXECR: begin
        o_mcctrl_alusrca = SRCA_RS1;
        o_mcctrl_aluop   = ALUOP_FN;
      end
      S_EXECI: begin
        o_mcctrl_alusrca = SRCA_RS1;
        o_mcctrl_alusrcb = SRCB_IMM;
        o_mcctrl_aluop   = ALUOP_FN;
      end
      S_ALUWB: begin
        o_mcctrl_regwrite = 1'b1;
      end
      S_BRANCH: begin
        o_mcctrl_alusrca = SRCA_RS1;
        o_mcctrl_aluop   = ALUOP_CMP;
        o_mcctrl_pcwrite = i_mcctrl_take;
      end
      S_JALR: begin
        o_mcctrl_alusrca = SRCA_RS1;
        o_mcctrl_alusrcb = SRCB_IMM;
      end
      S_JAL: begin
        o_mcctrl_pcwrite = 1'b1;
        o_mcctrl_alusrca = SRCA_OLDPC;
        o_mcctrl_alusrcb = SRCB_FOUR;
      end
      S_UIMM: begin
        o_mcctrl_immsrc  = IMM_U;
        o_mcctrl_alusrcb = SRCB_IMM;
        o_mcctrl_alusrca = i_mcctrl_opcode[5] ?
                           SRCA_ZERO : SRCA_OLDPC;
      end
      default: ;
    endcase
  end

  assign o_mcctrl_illegal = r_illegal;
  assign o_mcctrl_buserr  = r_buserr;
  assign o_mcctrl_state   = r_state;

endmodule

// File: tb/tb_riscv_core_mcctrl.sv
// Randomized bench for riscv_core_mcctrl against
// an instruction-level reference model.
module tb_riscv_core_mcctrl;

  localparam int TMO = 4;

  localparam logic [3:0] BOOT = 0, FETCH = 1;
  localparam logic [3:0] DECODE = 2, MEMADR = 3;
  localparam logic [3:0] MEMRD = 4, MEMWB = 5;
  localparam logic [3:0] MEMWR = 6, EXECR = 7;
  localparam logic [3:0] EXECI = 8, ALUWB = 9;
  localparam logic [3:0] BRANCH = 10, JALR = 11;
  localparam logic [3:0] JAL = 12, UIMM = 13;
  localparam logic [3:0] TRAP = 14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] i_opc = '0;
  logic       i_rdy = 1'b0;
  logic       i_take = 1'b0;
  logic       i_tclr = 1'b0;

  logic       pcw, irw, rw, mr, mw, ad;
  logic [2:0] im;
  logic [1:0] sa, sb, aop, rs;
  logic       ill, be;
  logic [3:0] st;

  logic [18:0] outv;
  assign outv = {pcw, irw, rw, mr, mw, ad, im,
                 sa, sb, aop, rs, ill, be};

  int  total = 0;
  int  bad = 0;
  int  n = 0;
  logic m_il = 1'b0;
  logic m_be = 1'b0;

  riscv_core_mcctrl #(
    .MEM_TIMEOUT (TMO),
    .TO_W        (8)
  ) dut (
    .i_mcctrl_clk       (clk),
    .i_mcctrl_rst_n     (rst_n),
    .i_mcctrl_opcode    (i_opc),
    .i_mcctrl_mem_ready (i_rdy),
    .i_mcctrl_take      (i_take),
    .i_mcctrl_trap_clr  (i_tclr),
    .o_mcctrl_pcwrite   (pcw),
    .o_mcctrl_irwrite   (irw),
    .o_mcctrl_regwrite  (rw),
    .o_mcctrl_memreq    (mr),
    .o_mcctrl_memwe     (mw),
    .o_mcctrl_adrsrc    (ad),
    .o_mcctrl_immsrc    (im),
    .o_mcctrl_alusrca   (sa),
    .o_mcctrl_alusrcb   (sb),
    .o_mcctrl_aluop     (aop),
    .o_mcctrl_resultsrc (rs),
    .o_mcctrl_illegal   (ill),
    .o_mcctrl_buserr    (be),
    .o_mcctrl_state     (st)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return logic'($urandom % 2);
  endfunction

  // expected outputs in a given state
  function automatic logic [18:0] ev(
    input logic [3:0] s, input logic [6:0] op,
    input logic r, input logic t,
    input logic fi, input logic fb);
    logic p, iw, w, q, we, a;
    logic [2:0] m;
    logic [1:0] xa, xb, xo, xr;
    p = 0; iw = 0; w = 0; q = 0; we = 0; a = 0;
    m = 0; xa = 0; xb = 0; xo = 0; xr = 0;
    case (s)
      FETCH:  begin q = 1; xb = 2; xr = 2;
                    p = r; iw = r; end
      DECODE: begin xa = 1; xb = 1;
                    m = (op == 7'b1101111) ? 3 : 2; end
      MEMADR: begin xa = 2; xb = 1;
                    m = op[5] ? 1 : 0; end
      MEMRD:  begin q = 1; a = 1; end
      MEMWB:  begin xr = 1; w = 1; end
      MEMWR:  begin q = 1; we = 1; a = 1; end
      EXECR:  begin xa = 2; xo = 2; end
      EXECI:  begin xa = 2; xb = 1; xo = 2; end
      ALUWB:  w = 1;
      BRANCH: begin xa = 2; xo = 1; p = t; end
      JALR:   begin xa = 2; xb = 1; end
      JAL:    begin p = 1; xa = 1; xb = 2; end
      UIMM:   begin m = 4; xb = 1;
                    xa = op[5] ? 3 : 1; end
      default: ;
    endcase
    return {p, iw, w, q, we, a, m,
            xa, xb, xo, xr, fi, fb};
  endfunction

  // instruction class from the opcode
  function automatic int cls(input logic [6:0] op);
    case (op)
      7'b0000011: return 0;
      7'b0100011: return 1;
      7'b0110011, 7'b0111011: return 2;
      7'b0010011, 7'b0011011: return 3;
      7'b1100011: return 4;
      7'b1101111: return 5;
      7'b1100111: return 6;
      7'b0110111, 7'b0010111: return 7;
      default: return 8;
    endcase
  endfunction

  function automatic int nom(input int k);
    case (k)
      0: return 5;
      4: return 3;
      6: return 5;
      default: return 4;
    endcase
  endfunction

  task automatic tick(input logic [3:0] s,
                      input logic r, input logic c,
                      input logic t);
    i_rdy = r; i_tclr = c; i_take = t;
    @(negedge clk);
    check("state", 32'(st), 32'(s));
    check("outs", 32'(outv),
          32'(ev(s, i_opc, r, t, m_il, m_be)));
    n++;
    @(posedge clk); #1;
  endtask

  // memory phase: ready after d unanswered cycles
  task automatic mem_phase(input logic [3:0] s,
                           input int d,
                           output bit ok);
    ok = 0;
    for (int i = 0; i <= TMO; i++) begin
      if (i == d) begin
        tick(s, 1'b1, rb(), rb());
        ok = 1;
        return;
      end
      tick(s, 1'b0, rb(), rb());
    end
    m_be = 1'b1;
  endtask

  task automatic trap_seq();
    tick(TRAP, rb(), 1'b0, rb());
    tick(TRAP, rb(), 1'b0, rb());
    tick(TRAP, rb(), 1'b1, rb());
    m_il = 1'b0;
    m_be = 1'b0;
  endtask

  task automatic run_instr(input logic [6:0] op,
                           input int fd, input int md,
                           input logic t);
    int k;
    bit ok;
    i_opc = op;
    n = 0;
    k = cls(op);
    mem_phase(FETCH, fd, ok);
    if (!ok) begin trap_seq(); return; end
    tick(DECODE, rb(), rb(), rb());
    case (k)
      0: begin
        tick(MEMADR, rb(), rb(), rb());
        mem_phase(MEMRD, md, ok);
        if (!ok) begin trap_seq(); return; end
        tick(MEMWB, rb(), rb(), rb());
      end
      1: begin
        tick(MEMADR, rb(), rb(), rb());
        mem_phase(MEMWR, md, ok);
        if (!ok) begin trap_seq(); return; end
      end
      2: begin
        tick(EXECR, rb(), rb(), rb());
        tick(ALUWB, rb(), rb(), rb());
      end
      3: begin
        tick(EXECI, rb(), rb(), rb());
        tick(ALUWB, rb(), rb(), rb());
      end
      4: tick(BRANCH, rb(), rb(), t);
      5: begin
        tick(JAL, rb(), rb(), rb());
        tick(ALUWB, rb(), rb(), rb());
      end
      6: begin
        tick(JALR, rb(), rb(), rb());
        tick(JAL, rb(), rb(), rb());
        tick(ALUWB, rb(), rb(), rb());
      end
      7: begin
        tick(UIMM, rb(), rb(), rb());
        tick(ALUWB, rb(), rb(), rb());
      end
      default: begin
        m_il = 1'b1;
        trap_seq();
        return;
      end
    endcase
    if (fd == 0 && (k > 1 || md == 0))
      check("cycles", 32'(n), 32'(nom(k)));
  endtask

  logic [6:0] ops [12];
  initial begin
    ops[0] = 7'b0000011; ops[1] = 7'b0100011;
    ops[2] = 7'b0110011; ops[3] = 7'b0111011;
    ops[4] = 7'b0010011; ops[5] = 7'b0011011;
    ops[6] = 7'b1100011; ops[7] = 7'b1101111;
    ops[8] = 7'b1100111; ops[9] = 7'b0110111;
    ops[10] = 7'b0010111; ops[11] = 7'b1111111;
  end

  function automatic int rdelay();
    int r;
    r = int'($urandom % 10);
    if (r < 6) return 0;
    if (r < 9) return int'($urandom_range(1, TMO));
    return TMO + 3;
  endfunction

  initial begin
    bit ok;
    logic [6:0] op;
    repeat (2) begin
      @(negedge clk);
      check("rst_state", 32'(st), 32'(BOOT));
      check("rst_outs", 32'(outv), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(BOOT, rb(), rb(), rb());

    run_instr(7'b0010011, 0, 0, 1'b0);
    run_instr(7'b0000011, 3, 3, 1'b0);
    run_instr(7'b1100011, 0, 0, 1'b0);
    run_instr(7'b1100011, 0, 0, 1'b1);
    run_instr(7'b1101111, 0, 0, 1'b0);
    run_instr(7'b1100111, 0, 0, 1'b0);
    run_instr(7'b0010011, TMO + 5, 0, 1'b0);
    run_instr(7'b0010011, TMO, 0, 1'b0);
    run_instr(7'b0000011, 0, TMO + 5, 1'b0);
    run_instr(7'b0100011, 0, TMO, 1'b0);
    run_instr(7'b1111111, 0, 0, 1'b0);
    run_instr(7'b0110111, 0, 0, 1'b0);
    run_instr(7'b0010111, 0, 0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      if ($urandom % 8 == 0)
        op = 7'($urandom);
      else
        op = ops[$urandom % 12];
      run_instr(op, rdelay(), rdelay(), rb());
    end

    i_opc = 7'b0100011;
    n = 0;
    mem_phase(FETCH, 0, ok);
    tick(DECODE, rb(), rb(), rb());
    tick(MEMADR, rb(), rb(), rb());
    tick(MEMWR, 1'b0, 1'b0, 1'b0);
    i_rdy = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_state", 32'(st), 32'(BOOT));
    check("async_memwe", 32'(mw), 32'd0);
    check("async_memreq", 32'(mr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_il = 1'b0;
    m_be = 1'b0;
    tick(BOOT, rb(), rb(), rb());
    run_instr(7'b0110011, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time=%0t limit=2000000",
             $time);
    $fatal(1);
  end

endmodule

// File: doc/riscv_core_mcctrl.md
Name: riscv_core_mcctrl

Overview:
- Multi-cycle main control FSM for the RV64I core.
- Sequences one shared ALU, the immediate extender, the register file and a single unified memory port through fetch/decode/execute/memory/writeback.
- Generates every datapath select, including the 3-bit immediate-format select, and runs the ready-based memory handshake with a timeout.
- Traps on illegal opcodes or memory timeout.

Parameters:
- MEM_TIMEOUT, 255, max cycles a memory request waits for ready before bus-error trap; legal range 1..255.
- TO_W, 8, width of the timeout counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- i_mcctrl_clk  in  1  clock, rising edge
- i_mcctrl_rst_n  in  1  asynchronous active-low reset
- i_mcctrl_opcode  in  7  instr[6:0] from the instruction register, stable from DECODE onward
- i_mcctrl_mem_ready  in  1  memory completes the current request this cycle
- i_mcctrl_take  in  1  branch condition from the comparator, valid in BRANCH
- i_mcctrl_trap_clr  in  1  leave TRAP
- o_mcctrl_pcwrite  out  1  PC load enable
- o_mcctrl_irwrite  out  1  IR load enable
- o_mcctrl_regwrite  out  1  register-file write enable
- o_mcctrl_memreq  out  1  memory request
- o_mcctrl_memwe  out  1  memory write qualifier
- o_mcctrl_adrsrc  out  1  address source: 0=PC, 1=ALUOut
- o_mcctrl_immsrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
- o_mcctrl_alusrca  out  2  ALU A operand: 00 PC, 01 oldPC, 10 rs1, 11 zero
- o_mcctrl_alusrcb  out  2  ALU B operand: 00 rs2, 01 imm, 10 const 4
- o_mcctrl_aluop  out  2  ALU operation: 00 add, 01 compare, 10 funct-decoded
- o_mcctrl_resultsrc  out  2  result mux: 00 ALUOut, 01 memdata, 10 ALU direct
- o_mcctrl_illegal  out  1  sticky illegal-opcode flag
- o_mcctrl_buserr  out  1  sticky memory-timeout flag
- o_mcctrl_state  out  4  current state, debug only

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous, active-low. Reset forces state BOOT, timeout counter 0 and both flags 0.
- Outputs: Moore, decoded from the state; the only exceptions are pcwrite in BRANCH and the wait-dependent strobes noted below. Any select not listed for a state is 0.
- Reset output values: every strobe 0, o_mcctrl_state = 0 (BOOT).
- State encoding: BOOT=0, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, JALR, JAL, UIMM, TRAP=14.
- BOOT: all strobes 0 → FETCH next cycle.
- FETCH: memreq=1, adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10.
  - irwrite and pcwrite are asserted only in the ready cycle.
  - On ready → DECODE.
- DECODE: alusrca=01, alusrcb=01, immsrc=011 if opcode is JAL, else 010. This precomputes the target into ALUOut.
- DECODE dispatch by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 or 0111011 → EXECR
  - 0010011 or 0011011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 or 0010111 → UIMM
  - anything else → TRAP with illegal set
- MEMADR: alusrca=10, alusrcb=01. immsrc=001 if opcode[5]=1, else 000. Next state MEMWR if opcode[5]=1, else MEMRD.
- MEMRD: memreq=1, adrsrc=1; waits for ready → MEMWB.
- MEMWB: resultsrc=01, regwrite=1 → FETCH.
- MEMWR: memreq=1, memwe=1, adrsrc=1; waits for ready → FETCH.
- EXECR: alusrca=10, alusrcb=00, aluop=10 → ALUWB.
- EXECI: alusrca=10, alusrcb=01, immsrc=000, aluop=10 → ALUWB.
- ALUWB: resultsrc=00, regwrite=1 → FETCH.
- BRANCH: alusrca=10, alusrcb=00, aluop=01, resultsrc=00; pcwrite = i_mcctrl_take → FETCH.
- JALR: alusrca=10, alusrcb=01, immsrc=000, aluop=00 (computes the target into ALUOut) → JAL.
- JAL: pcwrite=1, resultsrc=00 (PC ← ALUOut); alusrca=01, alusrcb=10, aluop=00 (oldPC+4) → ALUWB.
- UIMM: immsrc=100, alusrcb=01, aluop=00. alusrca=11 if opcode[5]=1 (LUI), else 01 (AUIPC) → ALUWB.
- Timeout counter:
  - Cleared on every entry into FETCH, MEMRD or MEMWR.
  - Increments each cycle with memreq=1 and ready=0.
  - Saturates at MEM_TIMEOUT.
  - When it equals MEM_TIMEOUT with ready still 0: → TRAP, buserr set, memreq drops the next cycle.
  - Ready in the same cycle the count reaches MEM_TIMEOUT wins: normal transition, no trap.
  - Ready on the first request cycle gives a 1-cycle memory state.
- TRAP: all strobes 0, flags held.
  - On trap_clr → FETCH, both flags cleared.
  - trap_clr outside TRAP is ignored.
- Reset mid-operation aborts immediately. Writes in flight are dropped, since no strobe survives reset.
- Nominal cycle counts with a zero-wait memory: load 5, store 4, R/I-type 4, branch 3, JAL 4, JALR 5, LUI/AUIPC 4.

Decomposition:
- Package riscv_core_pkg holds:
  - state localparams
  - opcode constants
  - IMM_I/S/B/J/U encodings
  - ALUOP, SRCA, SRCB and RESULT encodings

  The immediate extender shares the same IMM_* constants.
- Sub-module riscv_core_mcctrl_timeout: counter plus expiry compare, with clear, inc, ready inputs and an expired output.

Test Plan:
- Reset then ADDI (opcode 0010011), ready held 1:
  - states BOOT, FETCH, DECODE, EXECI, ALUWB, FETCH
  - immsrc=000 in EXECI
  - regwrite=1 for exactly one cycle
- LW with ready delayed 3 cycles in both FETCH and MEMRD:
  - memreq stays high 4 cycles each
  - irwrite pulses only on the ready cycle
  - resultsrc=01 in MEMWB
- BEQ with take=0, then with take=1: pcwrite=0 and 1 respectively in BRANCH; DECODE immsrc=010.
- JAL then JALR:
  - JAL: DECODE immsrc=011, JAL state pcwrite=1, then ALUWB regwrite=1
  - JALR visits JALR→JAL→ALUWB with immsrc=000
- Timeout:
  - MEM_TIMEOUT=4, ready never asserted in FETCH → TRAP, buserr=1, memreq=0.
  - trap_clr → FETCH, buserr=0.
  - Repeat with ready on the 4th wait cycle → no trap.
- Illegal opcode 1111111 → DECODE→TRAP, illegal=1. Assert reset mid-MEMWR → state=0 and memwe=0 asynchronously.
